// File: rtl/pipe_delay_line.sv
// WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits, a run-time output tap,
// stall/flush control, and a running XOR checksum plus saturating count of delivered words.
module pipe_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAPW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             vin,
    input  logic [TAPW-1:0]  tap,
    output logic [WIDTH-1:0] dout,
    output logic             vout,
    output logic [WIDTH-1:0] chk,
    output logic [15:0]      cnt
);

    logic [WIDTH-1:0] s [DEPTH];
    logic [DEPTH-1:0] v;
    logic [TAPW-1:0]  sel;
    logic             deliver;

    // Stage index for the clamped tap: 0 behaves as 1, anything past DEPTH as DEPTH.
    always_comb begin
        if (tap == '0) begin
            sel = '0;
        end else if (tap > TAPW'(DEPTH)) begin
            sel = TAPW'(DEPTH - 1);
        end else begin
            sel = tap - TAPW'(1);
        end
    end

    always_comb begin
        dout = '0;
        vout = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel == TAPW'(i)) begin
                dout = s[i];
                vout = v[i];
            end
        end
    end

    assign deliver = en && !flush && vout;

    // Flush clears only the valid bits, so stage data stays put and nothing is delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= '0;
            end
            v   <= '0;
            chk <= '0;
            cnt <= '0;
        end else if (flush) begin
            v <= '0;
        end else if (en) begin
            s[0] <= din;
            v[0] <= vin;
            for (int i = 1; i < DEPTH; i++) begin
                s[i] <= s[i-1];
                v[i] <= v[i-1];
            end
            if (deliver) begin
                chk <= chk ^ dout;
                if (cnt != 16'hFFFF) begin
                    cnt <= cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_delay_line.sv
// Scoreboard bench for pipe_delay_line: stimulus pushes expected words with their due enabled-edge
// count, a negedge monitor pops and compares whenever the pipeline advances.
module tb_pipe_delay_line;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int TAPW  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             vin = 1'b0;
    logic [TAPW-1:0]  tap = '0;
    logic [WIDTH-1:0] dout;
    logic             vout;
    logic [WIDTH-1:0] chk;
    logic [15:0]      cnt;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    exp_t q[$];
    int   en_edges = 0;
    int   last_edges = 0;
    int   tests_run = 0;
    int   fails = 0;

    pipe_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAPW(TAPW)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .vin(vin),
        .tap(tap), .dout(dout), .vout(vout), .chk(chk), .cnt(cnt)
    );

    always #5 clk = ~clk;

    // Counts posedges on which the pipeline actually shifts, from the bench's own drive values.
    always @(posedge clk) begin
        if (!rst && !flush && en) en_edges <= en_edges + 1;
    end

    function automatic int eff_tap(input logic [TAPW-1:0] tp);
        if (tp == 0) return 1;
        if (int'(tp) > DEPTH) return DEPTH;
        return int'(tp);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic e, input logic vi,
                                 input logic [WIDTH-1:0] d, input logic [TAPW-1:0] tp);
        @(negedge clk);
        #1;
        rst = r; flush = f; en = e; vin = vi; din = d; tap = tp;
        if (r || f) begin
            q.delete();
        end else if (e && vi) begin
            q.push_back('{data: d, due: en_edges + eff_tap(tp)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic [TAPW-1:0] tp);
        applyStimulus(1, 0, 0, 0, 8'h00, tp);
        applyStimulus(1, 0, 0, 0, 8'h00, tp);
        applyStimulus(0, 0, 0, 0, 8'h00, tp);
    endtask

    // Monitor: each time the pipeline advances, a valid tap must match the oldest expected word on time.
    always @(negedge clk) begin
        if (en_edges != last_edges) begin
            last_edges = en_edges;
            if (vout) begin
                tests_run++;
                if (q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_word: got %0h with vout=1, expected no valid word", dout);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    if (dout !== x.data || en_edges != x.due) begin
                        fails++;
                        $display("[TB] FAIL scoreboard_word: got %0h at edge %0d, expected %0h at edge %0d",
                                 dout, en_edges, x.data, x.due);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= en_edges) begin
                exp_t x;
                x = q.pop_front();
                tests_run++;
                fails++;
                $display("[TB] FAIL missing_word: got vout=0, expected %0h at edge %0d", x.data, x.due);
            end
        end
    end

    initial begin
        // Reset, tap=3 sequence and checksum
        doReset(4'd3);
        checkOutput("reset_dout", {24'b0, dout}, 32'h0);
        checkOutput("reset_vout", {31'b0, vout}, 32'h0);
        checkOutput("reset_chk", {24'b0, chk}, 32'h0);
        checkOutput("reset_cnt", {16'b0, cnt}, 32'h0);
        applyStimulus(0, 0, 1, 1, 8'h11, 4'd3);
        applyStimulus(0, 0, 1, 1, 8'h22, 4'd3);
        checkOutput("lat3_not_yet", {31'b0, vout}, 32'h0);
        applyStimulus(0, 0, 1, 1, 8'h33, 4'd3);
        checkOutput("lat3_dout", {24'b0, dout}, 32'h11);
        applyStimulus(0, 0, 1, 0, 8'h00, 4'd3);
        checkOutput("seq_chk1", {24'b0, chk}, 32'h11);
        applyStimulus(0, 0, 1, 0, 8'h00, 4'd3);
        checkOutput("seq_chk2", {24'b0, chk}, 32'h33);
        checkOutput("seq_cnt2", {16'b0, cnt}, 32'h2);
        applyStimulus(0, 0, 1, 0, 8'h00, 4'd3);
        checkOutput("seq_chk3", {24'b0, chk}, 32'h00);
        checkOutput("seq_cnt3", {16'b0, cnt}, 32'h3);

        // Stall with tap=2
        doReset(4'd2);
        applyStimulus(0, 0, 1, 1, 8'hA5, 4'd2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 8'h00, 4'd2);
            checkOutput("stall_vout", {31'b0, vout}, 32'h0);
        end
        applyStimulus(0, 0, 1, 0, 8'h00, 4'd2);
        checkOutput("stall_dout", {24'b0, dout}, 32'hA5);
        checkOutput("stall_vout_after", {31'b0, vout}, 32'h1);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'd2);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'd2);
        checkOutput("stall_hold_cnt", {16'b0, cnt}, 32'h0);
        checkOutput("stall_hold_chk", {24'b0, chk}, 32'h0);
        applyStimulus(0, 0, 1, 0, 8'h00, 4'd2);
        checkOutput("stall_deliver_chk", {24'b0, chk}, 32'hA5);
        checkOutput("stall_deliver_cnt", {16'b0, cnt}, 32'h1);

        // Flush mid-stream, tap=4
        doReset(4'd4);
        applyStimulus(0, 0, 1, 1, 8'h01, 4'd4);
        applyStimulus(0, 0, 1, 1, 8'h02, 4'd4);
        applyStimulus(0, 0, 1, 1, 8'h03, 4'd4);
        applyStimulus(0, 0, 1, 1, 8'h04, 4'd4);
        checkOutput("preflush_vout", {31'b0, vout}, 32'h1);
        applyStimulus(0, 1, 1, 1, 8'h99, 4'd4);
        checkOutput("flush_vout", {31'b0, vout}, 32'h0);
        checkOutput("flush_s0", {24'b0, dut.s[0]}, 32'h04);
        checkOutput("flush_s3", {24'b0, dut.s[3]}, 32'h01);
        checkOutput("flush_chk", {24'b0, chk}, 32'h0);
        checkOutput("flush_cnt", {16'b0, cnt}, 32'h0);
        applyStimulus(0, 0, 1, 1, 8'h55, 4'd4);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 8'h00, 4'd4);
        checkOutput("postflush_dout", {24'b0, dout}, 32'h55);
        applyStimulus(0, 0, 1, 0, 8'h00, 4'd4);
        checkOutput("postflush_chk", {24'b0, chk}, 32'h55);
        checkOutput("postflush_cnt", {16'b0, cnt}, 32'h1);

        // Tap clamping
        doReset(4'd0);
        applyStimulus(0, 0, 1, 1, 8'h3C, 4'd0);
        checkOutput("tap0_vout", {31'b0, vout}, 32'h1);
        checkOutput("tap0_dout", {24'b0, dout}, 32'h3C);
        applyStimulus(0, 0, 1, 0, 8'h00, 4'd0);
        checkOutput("tap0_cnt", {16'b0, cnt}, 32'h1);
        doReset(4'd15);
        applyStimulus(0, 0, 1, 1, 8'h3C, 4'd15);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0, 8'h00, 4'd15);
        checkOutput("tap15_not_yet", {31'b0, vout}, 32'h0);
        applyStimulus(0, 0, 1, 0, 8'h00, 4'd15);
        checkOutput("tap15_dout", {24'b0, dout}, 32'h3C);
        applyStimulus(0, 0, 1, 0, 8'h00, 4'd15);
        checkOutput("tap15_chk", {24'b0, chk}, 32'h3C);

        // Bubbles: only FF words enter the checksum
        doReset(4'd2);
        applyStimulus(0, 0, 1, 1, 8'hFF, 4'd2);
        applyStimulus(0, 0, 1, 0, 8'hAA, 4'd2);
        applyStimulus(0, 0, 1, 1, 8'hFF, 4'd2);
        applyStimulus(0, 0, 1, 0, 8'hAA, 4'd2);
        applyStimulus(0, 0, 1, 1, 8'hFF, 4'd2);
        checkOutput("bubble_chk2", {24'b0, chk}, 32'h00);
        checkOutput("bubble_cnt2", {16'b0, cnt}, 32'h2);
        applyStimulus(0, 0, 1, 0, 8'hAA, 4'd2);
        applyStimulus(0, 0, 1, 0, 8'hAA, 4'd2);
        checkOutput("bubble_chk3", {24'b0, chk}, 32'hFF);
        checkOutput("bubble_cnt3", {16'b0, cnt}, 32'h3);

        // Saturation from a preloaded count
        force dut.cnt = 16'hFFFE;
        release dut.cnt;
        applyStimulus(0, 0, 1, 1, 8'h01, 4'd1);
        applyStimulus(0, 0, 1, 1, 8'h02, 4'd1);
        checkOutput("sat_cnt_reach", {16'b0, cnt}, 32'hFFFF);
        applyStimulus(0, 0, 1, 1, 8'h04, 4'd1);
        applyStimulus(0, 0, 1, 0, 8'h00, 4'd1);
        checkOutput("sat_cnt_hold", {16'b0, cnt}, 32'hFFFF);
        checkOutput("sat_chk", {24'b0, chk}, 32'hF8);

        // Reset wins over flush and enable
        applyStimulus(1, 1, 1, 1, 8'h77, 4'd1);
        checkOutput("rstprio_dout", {24'b0, dout}, 32'h0);
        checkOutput("rstprio_vout", {31'b0, vout}, 32'h0);
        checkOutput("rstprio_chk", {24'b0, chk}, 32'h0);
        checkOutput("rstprio_cnt", {16'b0, cnt}, 32'h0);
        checkOutput("rstprio_s0", {24'b0, dut.s[0]}, 32'h0);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/pipe_delay_line.md
Name: pipe_delay_line

Overview:
- Parametrised successor to the single-bit posedge D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline.
- Adds a run-time selectable output tap, a per-stage valid bit, a stall enable and a flush.
- Adds a running XOR checksum and a count of delivered words.
- Used wherever a data path needs a programmable latency to align against another path, and for bench-side stream integrity checks.

Parameters:
WIDTH, 8, data bits per stage (>=1)
DEPTH, 4, number of pipeline stages (1..15)
TAPW, 4, width of tap select port; 2^TAPW > DEPTH required

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous reset, active-high
en  input  1  advance pipeline this cycle; 0 = stall (hold)
flush  input  1  clear all valid bits
din  input  WIDTH  input data to stage 0
vin  input  1  din is valid
tap  input  TAPW  requested delay in enabled cycles
dout  output  WIDTH  data at selected tap
vout  output  1  valid at selected tap
chk  output  WIDTH  running XOR of all delivered words (registered)
cnt  output  16  number of delivered words, saturating (registered)

Behaviour:
- Reset is synchronous: only effective on a posedge with rst=1.
- Priority per posedge is rst > flush > en.
- rst: all stage data s[i]=0, all valid v[i]=0, chk=0, cnt=0. Hence dout=0 and vout=0 from the next cycle. rst mid-stream discards everything in flight.
- Effective tap: t = 1 if tap==0; t = DEPTH if tap>DEPTH; otherwise t = tap.
- dout = s[t-1] and vout = v[t-1]. Both are combinational selects of registered stages; there is no combinational path from din/vin to the outputs.
- en=1 (no flush, no rst):
  - s[0]<=din, v[0]<=vin.
  - s[i]<=s[i-1], v[i]<=v[i-1] for i=1..DEPTH-1.
  - Data captured with vin=1 appears at dout/vout exactly t enabled posedges later.
  - Words beyond stage DEPTH-1 are dropped.
- en=0: all stages, chk and cnt hold. Stall cycles do not count toward latency.
- Delivery: a word is delivered on a posedge where rst=0, flush=0, en=1 and vout=1 (values sampled before the edge).
  - On delivery: chk<=chk^dout, and cnt<=cnt+1 unless cnt==16'hFFFF, in which case cnt holds.
- flush=1 (rst=0):
  - All v[i]<=0; s[i] holds its value (no shift, even if en=1).
  - chk and cnt hold; there is no delivery that cycle.
  - vout=0 from the next cycle until new valid data reaches tap t.
- Tap change: takes effect immediately on dout/vout, with no re-timing.
  - Shrinking t can re-deliver a word already delivered at a deeper tap.
  - Growing t can skip words.
  - Both are intended; the checksum simply reflects whatever was delivered.
- vin=0 bubbles propagate with their data. Their data never enters chk or cnt.
- DEPTH=1 is legal: any tap selects stage 0.
- X on din with vin=0 must not corrupt chk.

Test Plan:
- Reset, tap sequence and checksum: rst=1 for 2 cycles, then rst=0, en=1, tap=3, vin=1, din=8'h11,8'h22,8'h33 on consecutive cycles.
  - dout/vout=0 right after reset; then vout=1 with dout=11,22,33 on the 3rd,4th,5th cycles after the first capture; chk=8'h00 after the third delivery; cnt=3.
- Stall: tap=2, capture A5, then en=0 for 4 cycles, then en=1.
  - dout=A5 with vout=1 only after the 2nd enabled posedge.
  - chk/cnt unchanged during the stall.
- Flush mid-stream: DEPTH=4, tap=4, fill with 01..04 valid, assert flush with en=1 for one cycle.
  - vout=0 next cycle; stage data unchanged; chk/cnt unchanged.
  - New valid word 55 appears 4 enabled cycles later.
- Tap clamping: tap=0 -> latency 1; tap=15 with DEPTH=4 -> latency 4. Check both with a single valid 3C.
- Bubbles and saturation:
  - Alternate vin=1/0 with din=FF/AA; chk accumulates only the FF words (FF,00,FF,...).
  - Preload-by-force cnt=FFFE, deliver 3 words -> cnt=FFFF and holds.
- Reset priority: rst=1 together with flush=1, en=1, vin=1.
  - Next cycle all outputs are 0; din is not captured.
